// File: rtl/mc_run_scheduler_pkg.sv
// mc_run_scheduler_pkg
// Shared definitions for the Monte-Carlo run scheduler slice:
//   - run FSM state encoding
//   - fixed-point table word format (3 integer / 15 fraction bits)
//   - helpers that derive accumulator and batch-result widths from LOGT/LOGN
// Optional feature macro used by the slice: MC_RUN_SCHED_TIMEOUT_EN
package mc_run_scheduler_pkg;

    localparam int DATA_W = 18;
    localparam int FRAC_W = 15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLIP    = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_COLLECT = 3'd4,
        S_HOLD    = 3'd5
    } run_state_e;

    // Per-core accumulator: one table word summed over T = 2^LOGT steps.
    function automatic int acc_w(input int logt);
        return DATA_W + logt;
    endfunction

    // Batch total: NCORES = 2^LOGN accumulators summed, so it cannot overflow.
    function automatic int res_w(input int logt, input int logn);
        return DATA_W + logt + logn;
    endfunction

endpackage

// File: rtl/mc_run_scheduler_if.sv
// mc_run_scheduler_if
// Bundles every non-clock/reset signal of mc_run_scheduler.
//   master : host + core bank side (drives load words, go, done, accumulators, ready)
//   slave  : scheduler side (drives write ports, switch, start, result, busy)
// With MC_RUN_SCHED_TIMEOUT_EN defined an extra oTimeout pulse is carried.
interface mc_run_scheduler_if #(
    parameter int NCORES = 4,
    parameter int LOGN   = 2,
    parameter int LOGT   = 9,
    parameter int PATHW  = 10
) ();
    import mc_run_scheduler_pkg::*;

    localparam int ACC_W = acc_w(LOGT);
    localparam int RES_W = res_w(LOGT, LOGN);

    logic [DATA_W-1:0]       iLoadData;
    logic                    iLoadValid;
    logic                    oLoadReady;
    logic                    iGo;
    logic [PATHW-1:0]        oSigmaWriteAddress;
    logic [LOGT-1:0]         oMuWriteAddress;
    logic [DATA_W-1:0]       oWriteData;
    logic                    oSigmaWE;
    logic                    oMuWE;
    logic                    oSwitch;
    logic                    oStart;
    logic [NCORES-1:0]       iCoreDone;
    logic [NCORES*ACC_W-1:0] iCoreAcc;
    logic [RES_W-1:0]        oResult;
    logic                    oResultValid;
    logic                    iResultReady;
    logic                    oBusy;
`ifdef MC_RUN_SCHED_TIMEOUT_EN
    logic                    oTimeout;
`endif

    modport master (
        output iLoadData, iLoadValid, iGo, iCoreDone, iCoreAcc, iResultReady,
        input  oLoadReady, oSigmaWriteAddress, oMuWriteAddress, oWriteData,
               oSigmaWE, oMuWE, oSwitch, oStart, oResult, oResultValid, oBusy
`ifdef MC_RUN_SCHED_TIMEOUT_EN
             , oTimeout
`endif
    );

    modport slave (
        input  iLoadData, iLoadValid, iGo, iCoreDone, iCoreAcc, iResultReady,
        output oLoadReady, oSigmaWriteAddress, oMuWriteAddress, oWriteData,
               oSigmaWE, oMuWE, oSwitch, oStart, oResult, oResultValid, oBusy
`ifdef MC_RUN_SCHED_TIMEOUT_EN
             , oTimeout
`endif
    );

endinterface

// File: rtl/mc_table_loader.sv
// mc_table_loader
// Streams host table words into the idle parameter-RAM bank.
// The first 2^PATHW accepted words go to the sigma table, the next T words to
// the mu table; after the last mu word the bank is marked full and the host is
// stalled until the run FSM clears it (bank flip).
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   load_data_i/valid_i  host word + valid
//   bank_clear_i         one-cycle clear of bank_full from the run FSM
//   load_ready_o         !bank_full
//   bank_full_o          idle bank holds a complete table set
//   sigma_addr_o/we_o    registered sigma write port
//   mu_addr_o/we_o       registered mu write port
//   wdata_o              registered broadcast write data
module mc_table_loader
    import mc_run_scheduler_pkg::*;
#(
    parameter int T     = 512,
    parameter int LOGT  = 9,
    parameter int PATHW = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              load_valid_i,
    input  logic              bank_clear_i,
    output logic              load_ready_o,
    output logic              bank_full_o,
    output logic [PATHW-1:0]  sigma_addr_o,
    output logic [LOGT-1:0]   mu_addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              sigma_we_o,
    output logic              mu_we_o
);

    localparam int CNT_W = ((PATHW > LOGT) ? PATHW : LOGT) + 1;
    localparam int SIG_N = 2 ** PATHW;
    localparam int LAST  = SIG_N + T - 1;

    logic [CNT_W-1:0]  count_q;
    logic              bank_full_q;
    logic [PATHW-1:0]  sigma_addr_q;
    logic [LOGT-1:0]   mu_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sigma_we_q;
    logic              mu_we_q;
    logic              accept_s;

    assign accept_s     = load_valid_i & ~bank_full_q;
    assign load_ready_o = ~bank_full_q;
    assign bank_full_o  = bank_full_q;
    assign sigma_addr_o = sigma_addr_q;
    assign mu_addr_o    = mu_addr_q;
    assign wdata_o      = wdata_q;
    assign sigma_we_o   = sigma_we_q;
    assign mu_we_o      = mu_we_q;

    // Load counter, bank_full flag and registered write ports.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q      <= '0;
            bank_full_q  <= 1'b0;
            sigma_addr_q <= '0;
            mu_addr_q    <= '0;
            wdata_q      <= '0;
            sigma_we_q   <= 1'b0;
            mu_we_q      <= 1'b0;
        end else if (accept_s) begin
            wdata_q <= load_data_i;
            if (count_q < CNT_W'(SIG_N)) begin
                sigma_addr_q <= PATHW'(count_q);
                sigma_we_q   <= 1'b1;
                mu_we_q      <= 1'b0;
            end else begin
                mu_addr_q  <= LOGT'(count_q - CNT_W'(SIG_N));
                mu_we_q    <= 1'b1;
                sigma_we_q <= 1'b0;
            end
            if (count_q == CNT_W'(LAST)) begin
                count_q     <= '0;
                bank_full_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end else begin
            // No acceptance while full, so the clear never races a last word.
            sigma_we_q <= 1'b0;
            mu_we_q    <= 1'b0;
            if (bank_clear_i) begin
                bank_full_q <= 1'b0;
            end else begin
                bank_full_q <= bank_full_q;
            end
        end
    end

endmodule

// File: rtl/mc_run_scheduler.sv
// mc_run_scheduler (top)
// Sequences NCORES Monte-Carlo pricing cores sharing a double-buffered
// parameter store: loads the idle bank (mc_table_loader), flips the bank
// switch, pulses start, waits for every core's done, then sums the per-core
// accumulators one per cycle and holds the batch total until the host takes it.
// Ports: CLK, iRST_N (async active-low) plus interface bus (slave modport).
// Optional macro MC_RUN_SCHED_TIMEOUT_EN: RUN watchdog of TIMEOUT cycles that
// aborts to IDLE with a one-cycle oTimeout pulse and no result.
module mc_run_scheduler
    import mc_run_scheduler_pkg::*;
#(
    parameter int NCORES  = 4,
    parameter int LOGN    = 2,
    parameter int T       = 512,
    parameter int LOGT    = 9,
    parameter int PATHW   = 10
`ifdef MC_RUN_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 4096
`endif
) (
    input  logic               CLK,
    input  logic               iRST_N,
    mc_run_scheduler_if.slave  bus
);

    localparam int ACC_W = acc_w(LOGT);
    localparam int RES_W = res_w(LOGT, LOGN);

    run_state_e        state_q;
    logic              switch_q;
    logic              start_q;
    logic              valid_q;
    logic [RES_W-1:0]  sum_q;
    logic [RES_W-1:0]  result_q;
    logic [NCORES-1:0] done_seen_q;
    logic [LOGN-1:0]   idx_q;
    logic              bank_full_s;
    logic              bank_clear_s;
    logic              all_done_s;
    logic [ACC_W-1:0]  acc_sel_s;
    logic [RES_W-1:0]  sum_next_s;
`ifdef MC_RUN_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);
    logic [TO_W-1:0]   run_cnt_q;
    logic              timeout_q;
    assign bus.oTimeout = timeout_q;
`endif

    mc_table_loader #(
        .T     (T),
        .LOGT  (LOGT),
        .PATHW (PATHW)
    ) u_loader (
        .clk_i        (CLK),
        .rst_ni       (iRST_N),
        .load_data_i  (bus.iLoadData),
        .load_valid_i (bus.iLoadValid),
        .bank_clear_i (bank_clear_s),
        .load_ready_o (bus.oLoadReady),
        .bank_full_o  (bank_full_s),
        .sigma_addr_o (bus.oSigmaWriteAddress),
        .mu_addr_o    (bus.oMuWriteAddress),
        .wdata_o      (bus.oWriteData),
        .sigma_we_o   (bus.oSigmaWE),
        .mu_we_o      (bus.oMuWE)
    );

    // The freshly filled bank is handed to the cores in FLIP, so the loader
    // may refill the other one from the following cycle.
    assign bank_clear_s = (state_q == S_FLIP);
    // A done pulse in the same cycle as the last recorded one still counts.
    assign all_done_s   = &(done_seen_q | bus.iCoreDone);
    assign acc_sel_s    = bus.iCoreAcc[int'(idx_q)*ACC_W +: ACC_W];
    assign sum_next_s   = sum_q + {{LOGN{1'b0}}, acc_sel_s};

    assign bus.oSwitch      = switch_q;
    assign bus.oStart       = start_q;
    assign bus.oResult      = result_q;
    assign bus.oResultValid = valid_q;
    assign bus.oBusy        = (state_q != S_IDLE);

    // Run FSM with registered control outputs and the accumulator collector.
    always_ff @(posedge CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            switch_q    <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            sum_q       <= '0;
            result_q    <= '0;
            done_seen_q <= '0;
            idx_q       <= '0;
`ifdef MC_RUN_SCHED_TIMEOUT_EN
            run_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef MC_RUN_SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    // Toggled on entry so oSwitch changes the cycle after iGo.
                    if (bus.iGo && bank_full_s) begin
                        state_q  <= S_FLIP;
                        switch_q <= ~switch_q;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_FLIP: begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    start_q     <= 1'b0;
                    done_seen_q <= '0;
`ifdef MC_RUN_SCHED_TIMEOUT_EN
                    run_cnt_q   <= '0;
`endif
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    done_seen_q <= done_seen_q | bus.iCoreDone;
                    if (all_done_s) begin
                        state_q <= S_COLLECT;
                        sum_q   <= '0;
                        idx_q   <= '0;
`ifdef MC_RUN_SCHED_TIMEOUT_EN
                    end else if (run_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_q   <= S_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        run_cnt_q <= run_cnt_q + TO_W'(1);
`else
                    end else begin
                        state_q <= S_RUN;
`endif
                    end
                end
                S_COLLECT: begin
                    sum_q <= sum_next_s;
                    if (idx_q == LOGN'(NCORES - 1)) begin
                        result_q <= sum_next_s;
                        valid_q  <= 1'b1;
                        state_q  <= S_HOLD;
                    end else begin
                        idx_q    <= idx_q + LOGN'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.iResultReady) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_run_scheduler.sv
// tb_mc_run_scheduler
// Directed bench for mc_run_scheduler with NCORES=2, T=4, LOGT=2, PATHW=2.
// Expected values are hand-computed constants. With MC_RUN_SCHED_TIMEOUT_EN
// defined the watchdog is built with TIMEOUT=20 and exercised at the end.
module tb_mc_run_scheduler;
    import mc_run_scheduler_pkg::*;

    localparam int NC = 2;
    localparam int LN = 1;
    localparam int TT = 4;
    localparam int LT = 2;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_run_scheduler_if #(.NCORES(NC), .LOGN(LN), .LOGT(LT), .PATHW(PW)) bus ();

    mc_run_scheduler #(
        .NCORES (NC),
        .LOGN   (LN),
        .T      (TT),
        .LOGT   (LT),
        .PATHW  (PW)
`ifdef MC_RUN_SCHED_TIMEOUT_EN
      , .TIMEOUT(20)
`endif
    ) dut (
        .CLK    (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Streams words 1..8 (4 sigma + 4 mu) one per cycle; call right after a negedge.
    task automatic load_bank();
        for (int i = 0; i < 8; i++) begin
            bus.iLoadData  = 18'(i + 1);
            bus.iLoadValid = 1'b1;
            @(negedge clk);
            check_val("ld_we", {30'd0, bus.oSigmaWE, bus.oMuWE}, (i < 4) ? 32'd2 : 32'd1);
            check_val("ld_addr", (i < 4) ? 32'(bus.oSigmaWriteAddress) : 32'(bus.oMuWriteAddress), 32'(i % 4));
            check_val("ld_data", 32'(bus.oWriteData), 32'(i + 1));
        end
        bus.iLoadValid = 1'b0;
        check_val("ld_ready_drop", 32'(bus.oLoadReady), 32'd0);
        @(negedge clk);
        check_val("ld_we_idle", {30'd0, bus.oSigmaWE, bus.oMuWE}, 32'd0);
        check_val("ld_ready_full", 32'(bus.oLoadReady), 32'd0);
    endtask

    // iGo with a full bank; leaves the caller at the first RUN-cycle negedge.
    task automatic go_run(input logic exp_sw);
        bus.iGo = 1'b1;
        @(negedge clk);
        bus.iGo = 1'b0;
        check_val("go_switch", 32'(bus.oSwitch), 32'(exp_sw));
        check_val("go_start_c1", 32'(bus.oStart), 32'd0);
        check_val("go_busy", 32'(bus.oBusy), 32'd1);
        check_val("go_ready_c1", 32'(bus.oLoadReady), 32'd0);
        @(negedge clk);
        check_val("go_start_c2", 32'(bus.oStart), 32'd1);
        check_val("go_ready_c2", 32'(bus.oLoadReady), 32'd1);
        @(negedge clk);
        check_val("go_start_c3", 32'(bus.oStart), 32'd0);
        check_val("go_busy_run", 32'(bus.oBusy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iLoadData    = '0;
        bus.iLoadValid   = 1'b0;
        bus.iGo          = 1'b0;
        bus.iCoreDone    = '0;
        bus.iCoreAcc     = '0;
        bus.iResultReady = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_switch", 32'(bus.oSwitch), 32'd0);
        check_val("rst_start", 32'(bus.oStart), 32'd0);
        check_val("rst_busy", 32'(bus.oBusy), 32'd0);
        check_val("rst_valid", 32'(bus.oResultValid), 32'd0);
        check_val("rst_result", 32'(bus.oResult), 32'd0);
        check_val("rst_ready", 32'(bus.oLoadReady), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // iGo with an empty bank is ignored.
        bus.iGo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("empty_switch", 32'(bus.oSwitch), 32'd0);
            check_val("empty_start", 32'(bus.oStart), 32'd0);
            check_val("empty_busy", 32'(bus.oBusy), 32'd0);
        end
        bus.iGo = 1'b0;

        // Run 1: staggered done pulses, 0x3FFFF + 0x00010 = 0x4000F.
        load_bank();
        bus.iCoreAcc = {20'h3FFFF, 20'h00010};
        go_run(1'b1);
        repeat (3) @(negedge clk);
        bus.iCoreDone = 2'b01;
        @(negedge clk);
        bus.iCoreDone = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check_val("run1_wait_valid", 32'(bus.oResultValid), 32'd0);
            @(negedge clk);
        end
        bus.iCoreDone = 2'b10;
        @(negedge clk);
        bus.iCoreDone = 2'b00;
        check_val("run1_lat1", 32'(bus.oResultValid), 32'd0);
        @(negedge clk);
        check_val("run1_lat2", 32'(bus.oResultValid), 32'd0);
        @(negedge clk);
        check_val("run1_valid", 32'(bus.oResultValid), 32'd1);
        check_val("run1_result", 32'(bus.oResult), 32'h4000F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("run1_hold_valid", 32'(bus.oResultValid), 32'd1);
            check_val("run1_hold_result", 32'(bus.oResult), 32'h4000F);
            check_val("run1_hold_busy", 32'(bus.oBusy), 32'd1);
        end
        bus.iResultReady = 1'b1;
        @(negedge clk);
        bus.iResultReady = 1'b0;
        check_val("run1_taken_valid", 32'(bus.oResultValid), 32'd0);
        check_val("run1_idle", 32'(bus.oBusy), 32'd0);

        // Run 2: both done in one cycle, maximal accumulators -> 0x1FFFFE.
        load_bank();
        bus.iCoreAcc = {20'hFFFFF, 20'hFFFFF};
        go_run(1'b0);
        bus.iCoreDone = 2'b11;
        @(negedge clk);
        bus.iCoreDone = 2'b00;
        check_val("run2_lat1", 32'(bus.oResultValid), 32'd0);
        @(negedge clk);
        check_val("run2_lat2", 32'(bus.oResultValid), 32'd0);
        @(negedge clk);
        check_val("run2_valid", 32'(bus.oResultValid), 32'd1);
        check_val("run2_result", 32'(bus.oResult), 32'h1FFFFE);
        bus.iResultReady = 1'b1;
        @(negedge clk);
        bus.iResultReady = 1'b0;
        check_val("run2_taken_valid", 32'(bus.oResultValid), 32'd0);
        check_val("run2_idle", 32'(bus.oBusy), 32'd0);

        // Run 3: reset asserted mid-RUN.
        load_bank();
        go_run(1'b1);
        bus.iCoreDone = 2'b01;
        @(negedge clk);
        bus.iCoreDone = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_switch", 32'(bus.oSwitch), 32'd0);
        check_val("mid_rst_start", 32'(bus.oStart), 32'd0);
        check_val("mid_rst_busy", 32'(bus.oBusy), 32'd0);
        check_val("mid_rst_valid", 32'(bus.oResultValid), 32'd0);
        check_val("mid_rst_we", {30'd0, bus.oSigmaWE, bus.oMuWE}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_switch", 32'(bus.oSwitch), 32'd0);
        check_val("post_rst_ready", 32'(bus.oLoadReady), 32'd1);
        check_val("post_rst_busy", 32'(bus.oBusy), 32'd0);

`ifdef MC_RUN_SCHED_TIMEOUT_EN
        // Run 4: only core0 finishes; watchdog fires 20 cycles into RUN.
        load_bank();
        go_run(1'b1);
        bus.iCoreDone = 2'b01;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            bus.iCoreDone = 2'b00;
            check_val("to_early", 32'(bus.oTimeout), 32'd0);
        end
        @(negedge clk);
        check_val("to_pulse", 32'(bus.oTimeout), 32'd1);
        check_val("to_idle", 32'(bus.oBusy), 32'd0);
        @(negedge clk);
        check_val("to_pulse_end", 32'(bus.oTimeout), 32'd0);
        check_val("to_no_result", 32'(bus.oResultValid), 32'd0);
        check_val("to_switch_kept", 32'(bus.oSwitch), 32'd1);
        repeat (4) @(negedge clk);
        check_val("to_still_no_result", 32'(bus.oResultValid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_run_scheduler.md
Name: mc_run_scheduler

Overview:
- Sequences a bank of NCORES Monte-Carlo pricing cores that share one double-buffered parameter store.
- Streams exp(sigma) and exp(mu) tables from a host into the idle RAM bank.
- Flips the bank switch, pulses start, and waits for every core's done pulse.
- Sums the per-core accumulators and hands one batch total to the host over a valid/ready port.

Parameters:
NCORES, 4, number of cores driven (power of 2, >=2)
LOGN, 2, log2(NCORES)
T, 512, time steps per path
LOGT, 9, log2(T)
PATHW, 10, sigma table address width (2^PATHW entries)
TIMEOUT, 4096, watchdog cycles in RUN (optional feature only)

Ports:
CLK  in  1  clock, all state on rising edge
iRST_N  in  1  asynchronous active-low reset
iLoadData  in  18  table word (3 int/15 frac)
iLoadValid  in  1  load word valid
oLoadReady  out  1  load word accepted when valid&ready
iGo  in  1  request one batch run
oSigmaWriteAddress  out  PATHW  broadcast sigma write address
oMuWriteAddress  out  LOGT  broadcast mu write address
oWriteData  out  18  broadcast write data
oSigmaWE  out  1  sigma write enable
oMuWE  out  1  mu write enable
oSwitch  out  1  RAM bank select to all cores
oStart  out  1  one-cycle start pulse to all cores
iCoreDone  in  NCORES  per-core done pulses
iCoreAcc  in  NCORES*(18+LOGT)  packed accumulators, core k at bits [k*(18+LOGT) +: 18+LOGT]
oResult  out  18+LOGT+LOGN  batch sum
oResultValid  out  1  result valid, held until iResultReady
iResultReady  in  1  host consumes result
oBusy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0 (oSwitch=0), load counter 0, bank_full=0, FSM=IDLE; applies immediately, also mid-run.
- Loader, independent of the run FSM:
  - oLoadReady = !bank_full.
  - Accepted words 0..2^PATHW-1 drive the sigma port: address = count, oSigmaWE=1 the cycle after acceptance (registered).
  - Accepted words 2^PATHW..2^PATHW+T-1 drive the mu port: address = count-2^PATHW, oMuWE=1 likewise.
  - On the last mu word: counter wraps to 0, bank_full=1.
- Run FSM states: IDLE, FLIP, START, RUN, COLLECT, HOLD.
  - IDLE: iGo && bank_full -> FLIP. iGo without bank_full is ignored; it is level-sampled, not latched.
  - FLIP: toggle oSwitch, clear bank_full; the loader may refill the other bank from the next cycle -> START.
  - START: oStart=1 for exactly one cycle, clear done_seen[] -> RUN.
  - RUN: done_seen[k] |= iCoreDone[k]. When all set -> COLLECT, with sum cleared and index 0.
  - COLLECT: sum += zero-extended iCoreAcc[index], one core per cycle, NCORES cycles.
    - After the last add, oResult=sum, oResultValid=1 -> HOLD.
  - HOLD: on iResultReady, oResultValid=0 -> IDLE.
- Latency:
  - iGo sampled to oStart: 2 cycles.
  - Last done to oResultValid: NCORES+1 cycles.
- Simultaneous events:
  - A done pulse arriving in the same cycle as the last one still completes RUN.
  - A load-word acceptance in FLIP is impossible because bank_full=1 there.
- Arithmetic: unsigned, no saturation. The width of 18+LOGT+LOGN bits cannot overflow.
- iCoreDone pulses outside RUN are ignored.

Optional Feature:
MC_RUN_SCHED_TIMEOUT_EN:
- With the macro defined:
  - A cycle counter runs in RUN.
  - Reaching TIMEOUT with done_seen incomplete forces IDLE, pulses extra output oTimeout (1 bit) for one cycle, and produces no result.
  - oSwitch keeps its flipped value.
- Without the macro: no oTimeout port, and RUN waits indefinitely.

Decomposition:
- Shared package: FSM state enum, fixed-point width constants (DATA_W=18, FRAC_W=15), derived ACC_W=18+LOGT and RES_W.
- Natural sub-module mc_table_loader: load counter, bank_full flag, and both write ports.
- The run FSM and collector stay in the top.

Test Plan:
1. Load, NCORES=2, T=4, LOGT=2, PATHW=2:
   - Stream 8 words 0x1..0x8 -> sigma writes addr0..3 = 0x1..0x4, then mu writes addr0..3 = 0x5..0x8.
   - oLoadReady drops after the 8th word.
2. iGo with bank_full:
   - oSwitch 0->1 on cycle+1, oStart high only on cycle+2.
   - oLoadReady rises on cycle+2 (bank_full cleared in FLIP).
3. Staggered done pulses, core0 at t=10 and core1 at t=15, iCoreAcc = {0x3FFFF, 0x00010} -> oResultValid at t=18, oResult=0x4000F.
   - Hold iResultReady low 5 cycles -> oResult stable. Ready high -> FSM returns to IDLE.
4. iGo with bank empty -> no oSwitch change, no oStart, oBusy stays 0.
5. Deassert iRST_N during RUN -> all outputs 0 immediately. After release, oSwitch=0, oLoadReady=1.
6. MC_RUN_SCHED_TIMEOUT_EN defined, TIMEOUT=20, only core0 done -> oTimeout pulses 20 cycles after entering RUN, oResultValid never asserts.
